// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: frame FSM states, PS/2 framing constants and the parity helper.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

    // PS/2 uses odd parity: the 8 data bits plus the parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// ps2_sync_fifo: single-clock FIFO with count, full/empty and same-cycle push+pop.
// Latency: a pushed word is visible on o_rdat the cycle after the push.
// Backpressure: none inside; the caller must not push when full without a pop, nor pop when empty.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdat,
    output logic [WIDTH-1:0]           o_rdat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage needs no reset: nothing is read from an entry before it is written.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdat  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host deframer feeding a byte FIFO; optional clock glitch filter (PS2_RX_GLITCH_FILTER_EN).
// Latency: byte at data/ready one cycle after the stop-bit sample (SYNC_STAGES+1 clk after the last ps2_clk fall, +FILTER_LEN with filter).
// Backpressure: none toward the PS/2 device; a good frame arriving while full is dropped and flagged in overflow.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FILTER_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [PS2_DATA_BITS-1:0]      data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(PS2_DATA_BITS);

    // Reject parameter sets the logic below cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        TIMEOUT_CYC < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("ps2_rx_fifo: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0]   r_clk_sync;
    logic [SYNC_STAGES-1:0]   r_dat_sync;
    logic                     w_clk_s;
    logic                     w_dat_s;
    logic                     w_clk_e;
    logic                     r_clk_prev;
    logic                     w_sample;

    ps2_state_t               r_state;
    logic [BW-1:0]            r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_par;
    logic [TW-1:0]            r_to_cnt;

    logic                     w_stop_ev;
    logic                     w_good;
    logic                     w_timeout;
    logic                     w_par_set;
    logic                     w_frm_set;
    logic                     w_ovf_set;
    logic                     w_pop;
    logic                     w_fifo_push;
    logic                     w_full;
    logic                     w_empty;

    logic                     r_overflow;
    logic                     r_parity_err;
    logic                     r_frame_err;

    // Both lines see the same synchroniser depth so data stays aligned with the clock edge; idle-high reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] r_flt_cnt;
    logic           r_clk_flt;

    // Filtered clock follows the synchronised clock only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_flt_cnt <= '0;
            r_clk_flt <= 1'b1;
        end else if (w_clk_s == r_clk_flt) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == FCW'(FILTER_LEN - 1)) begin
            r_clk_flt <= w_clk_s;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    assign w_clk_e = r_clk_flt;
`else
    assign w_clk_e = w_clk_s;
`endif

    // Previous clock level for falling-edge detection.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_e;
        end
    end

    assign w_sample = r_clk_prev & ~w_clk_e;

    // Frame outcome is decided on the stop-bit sample so the push lands on that same cycle.
    assign w_stop_ev = w_sample && (r_state == STOP);
    assign w_good    = w_stop_ev && (w_dat_s == PS2_STOP_BIT) && odd_parity_ok(r_shift, r_par);
    assign w_par_set = w_stop_ev && (w_dat_s == PS2_STOP_BIT) && !odd_parity_ok(r_shift, r_par);
    assign w_timeout = !w_sample && (r_state != IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_frm_set = (w_sample && (r_state == IDLE) && (w_dat_s != PS2_START_BIT)) ||
                       (w_stop_ev && (w_dat_s != PS2_STOP_BIT)) ||
                       w_timeout;

    // Frame FSM with inter-bit timeout; only sample pulses advance it, the timeout forces it home.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else if (w_sample) begin
            r_to_cnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_dat_s == PS2_START_BIT) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    r_shift <= {w_dat_s, r_shift[PS2_DATA_BITS-1:1]};
                    if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
                        r_state <= PARITY;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    r_par   <= w_dat_s;
                    r_state <= STOP;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end else if (r_state != IDLE) begin
            if (w_timeout) begin
                r_state  <= IDLE;
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Drop-on-full: a good byte only enters when there is room or the head leaves the same cycle.
    assign w_pop       = rd_en & ready;
    assign w_fifo_push = w_good & (~w_full | w_pop);
    assign w_ovf_set   = w_good & w_full & ~w_pop;

    ps2_sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_wdat  (r_shift),
        .o_rdat  (data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign ready = ~w_empty;

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_overflow   <= w_ovf_set | (r_overflow   & ~err_clr);
            r_parity_err <= w_par_set | (r_parity_err & ~err_clr);
            r_frame_err  <= w_frm_set | (r_frame_err  & ~err_clr);
        end
    end

    assign overflow   = r_overflow;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed and randomized PS/2 frames checked against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int TMO   = 200;
    localparam int FLEN  = 4;
    localparam int H     = 20;
`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int LAT   = SYNC + 1 + FLEN;
`else
    localparam int LAT   = SYNC + 1;
`endif

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO),
        .FILTER_LEN  (FLEN)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .data       (data),
        .ready      (ready),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model: the FIFO contents as a queue plus the three sticky flags.
    logic [7:0] exp_q[$];
    bit e_ovf, e_par, e_frm;
    logic lat_b, lat_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ready"}, ready, exp_q.size() != 0);
        check({tag, ".count"}, count, exp_q.size());
        check({tag, ".overflow"}, overflow, e_ovf);
        check({tag, ".parity_err"}, parity_err, e_par);
        check({tag, ".frame_err"}, frame_err, e_frm);
        if (exp_q.size() != 0) check({tag, ".data"}, data, exp_q[0]);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    // Drives nbits bits LSB first; on the stop bit, optionally pulses rd_en (1) or err_clr (2) on the push cycle.
    task automatic drive_frame(input logic [10:0] bits, input int nbits, input int pulse);
        lat_b = 1'b0;
        lat_a = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int k = 1; k <= LAT; k++) begin
                    @(negedge clk);
                    if (k == LAT - 1) begin
                        lat_b = ready;
                        if (pulse == 1) rd_en = 1'b1;
                        if (pulse == 2) err_clr = 1'b1;
                    end
                    if (k == LAT) begin
                        lat_a = ready;
                        rd_en = 1'b0;
                        err_clr = 1'b0;
                    end
                end
                wait_cyc(H - LAT);
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int pulse);
        bit popped;
        bit was_full;
        popped   = (pulse == 1) && (exp_q.size() > 0);
        was_full = (exp_q.size() == DEPTH);
        if (pulse == 2) begin
            e_ovf = 0; e_par = 0; e_frm = 0;
        end
        if (popped) void'(exp_q.pop_front());
        if (bad_stop) e_frm = 1;
        else if (bad_par) e_par = 1;
        else if (was_full && !popped) e_ovf = 1;
        else exp_q.push_back(d);
    endtask

    task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int pulse);
        drive_frame(make_frame(d, bad_par, bad_stop), 11, pulse);
        model_frame(d, bad_par, bad_stop, pulse);
        wait_cyc(5);
    endtask

    task automatic pop_one(input string tag);
        check({tag, ".head"}, data, exp_q[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        check_state({tag, ".after"});
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        e_ovf = 0; e_par = 0; e_frm = 0;
    endtask

    initial begin
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        e_ovf = 0; e_par = 0; e_frm = 0;
        wait_cyc(5);
        check_state("reset");
        clrn = 1'b1;
        wait_cyc(5);

        // Single good frame and its push latency.
        send(8'h1C, 0, 0, 0);
        check("t1.ready_before_push", lat_b, 1'b0);
        check("t1.ready_after_push", lat_a, 1'b1);
        check_state("t1");
        pop_one("t1.pop");

        // Ordered delivery, one pop every three cycles.
        send(8'hF0, 0, 0, 0);
        send(8'h1C, 0, 0, 0);
        send(8'hE0, 0, 0, 0);
        check_state("t2.filled");
        for (int i = 0; i < 3; i++) begin
            pop_one("t2.pop");
            wait_cyc(2);
        end
        check_state("t2.drained");

        // Nine frames into eight entries: the ninth is dropped.
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 0, 0, 0);
        check_state("t3.full");
        clear_errs();
        check_state("t3.cleared");
        // Push and pop on the same cycle while full: both happen, no overflow.
        send(8'h77, 0, 0, 1);
        check_state("t3.full_pushpop");
        while (exp_q.size() != 0) pop_one("t3.drain");
        // Push with rd_en while empty: only the push happens.
        send(8'h5A, 0, 0, 1);
        check_state("t3.empty_pushpop");
        pop_one("t3.pop5a");
        rd_en = 1'b1;
        wait_cyc(3);
        rd_en = 1'b0;
        check_state("t3.rd_empty");

        // Parity and stop-bit errors.
        send(8'h1C, 1, 0, 0);
        check_state("t4.parity");
        send(8'h1C, 0, 1, 0);
        check_state("t4.stop");
        // err_clr on the cycle a parity error is flagged: the new error survives.
        send(8'h2B, 1, 0, 2);
        check_state("t4.set_wins");
        clear_errs();
        check_state("t4.cleared");

        // Timeout after four data bits.
        drive_frame(make_frame(8'h55, 0, 0), 5, 0);
        wait_cyc(TMO - 40);
        check("t5.no_early_timeout", frame_err, 1'b0);
        wait_cyc(60);
        e_frm = 1;
        check_state("t5.timeout");
        send(8'h2A, 0, 0, 0);
        check_state("t5.recover");
        pop_one("t5.pop");
        clear_errs();

        // Reset in the middle of a frame, then a clean frame.
        send(8'h66, 0, 0, 0);
        drive_frame(make_frame(8'hFF, 0, 0), 5, 0);
        clrn = 1'b0;
        wait_cyc(2);
        clrn = 1'b1;
        exp_q.delete();
        e_ovf = 0; e_par = 0; e_frm = 0;
        wait_cyc(3);
        check_state("t6.reset");
        send(8'h33, 0, 0, 0);
        check_state("t6.after");
        pop_one("t6.pop");

`ifdef PS2_RX_GLITCH_FILTER_EN
        // Short low pulses on ps2_clk must not shift bits or start a frame.
        ps2_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
        wait_cyc(20);
        check_state("t7.glitch");
        send(8'hA5, 0, 0, 0);
        check_state("t7.after");
        pop_one("t7.pop");
`endif

        // Random frames, random pops and clears.
        for (int it = 0; it < 16; it++) begin
            logic [7:0] d;
            int kind;
            int pulse;
            d     = 8'($urandom);
            kind  = $urandom_range(0, 7);
            pulse = ($urandom_range(0, 3) == 0) ? 1 : 0;
            send(d, kind == 6, kind == 7, pulse);
            check_state("rnd.frame");
            if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) pop_one("rnd.pop");
            if ($urandom_range(0, 4) == 0) begin
                clear_errs();
                check_state("rnd.clr");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) from the synchronised ps2_clk/ps2_data lines. Good bytes go into a depth-configurable FIFO read by downstream logic (scan-code decoder, MMIO keyboard register). Compared with the previous-generation receiver it adds:
- a frame state machine with inter-bit timeout;
- sticky parity and framing error flags;
- drop-on-full overflow, where the earlier block overwrote;
- an occupancy count;
- an active-high pop interface.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
SYNC_STAGES, 3, flip-flops in each input synchroniser; >= 2.
TIMEOUT_CYC, 100000, clk cycles allowed between falling ps2_clk edges inside a frame (2 ms at 50 MHz).
FILTER_LEN, 4, consecutive equal synchronised samples required by the glitch filter (optional feature only).

Ports:
clk  in  1  system clock; all logic on posedge.
clrn  in  1  reset, asynchronous assert, active-low.
ps2_clk  in  1  raw PS/2 clock line, asynchronous.
ps2_data  in  1  raw PS/2 data line, asynchronous.
rd_en  in  1  pop the head byte; ignored while ready=0.
err_clr  in  1  clears all sticky flags.
data  out  8  head byte of the FIFO; valid while ready=1.
ready  out  1  FIFO non-empty.
count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
parity_err  out  1  sticky: a frame failed the odd-parity check.
frame_err  out  1  sticky: bad start bit, bad stop bit, or timeout.

Behaviour:
- Reset (clrn=0, asynchronous):
  - State goes to IDLE; pointers, count, bit counter and timeout counter go to 0.
  - ready, overflow, parity_err and frame_err go to 0.
  - Synchronisers load 1 (bus idle-high).
  - data is don't-care while ready=0.
  - Reset mid-frame discards the partial frame. FIFO contents are lost.
- Sampling:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - A one-cycle sample pulse fires when the synchronised clock goes 1 -> 0.
  - ps2_data is taken from the same synchroniser depth.
- Frame FSM, advancing only on sample pulses:
  - IDLE: data=0 -> DATA with bit counter 0. data=1 -> set frame_err, stay IDLE.
  - DATA: shift the bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always -> IDLE. Then:
    - stop=0: set frame_err, no push.
    - XOR of the 8 data bits and the parity bit = 0: set parity_err, no push.
    - otherwise push the byte.
- Timeout:
  - The counter runs while state != IDLE and resets to 0 on every sample pulse.
  - When it reaches TIMEOUT_CYC - 1: go to IDLE, set frame_err, discard the frame.
  - The counter is held at 0 in IDLE.
- FIFO timing:
  - Push happens on the STOP-sample cycle. ready=1 and data is valid from the following cycle.
  - Pop when rd_en=1 and ready=1. data shows the next entry the cycle after the pop.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO boundary cases:
  - Push while full and no pop: byte dropped, overflow set, existing contents unchanged.
  - Push and pop in the same cycle while full: both proceed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push proceeds, because ready=0 blocks the pop.
  - rd_en while empty: no effect.
- Sticky flags:
  - err_clr clears all three flags.
  - If a flag's set condition and err_clr occur in the same cycle, set wins.

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- Defined: the synchronised ps2_clk feeds a filter whose output changes only after FILTER_LEN consecutive equal samples. Edge detection uses the filtered signal, adding FILTER_LEN cycles of latency. Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined: edge detection uses the synchronised ps2_clk directly, and FILTER_LEN is unused.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - PS2_START_BIT=0, PS2_STOP_BIT=1, PS2_DATA_BITS=8.
- Sub-module ps2_sync_fifo (WIDTH, DEPTH): synchronous FIFO with push, pop, full, empty, count and same-cycle push+pop. It contains no drop/overflow logic; the top level owns the overflow policy.

Test Plan:
1. Send frame 0x1C with correct parity and stop, at 10 kHz bit rate on a 50 MHz clk -> ready rises the cycle after the STOP sample; data=0x1C, count=1, all flags 0.
2. Send 0xF0, 0x1C, 0xE0, then pop one per 3 cycles -> data reads 0xF0, 0x1C, 0xE0 in order; ready=0 after the third pop.
3. Default depth: send 9 good frames with no pops -> count=8, overflow=1, the FIFO holds the first 8 bytes; err_clr clears overflow.
4. Send 0x1C with the parity bit flipped -> no push, parity_err=1, ready stays 0. A second frame with stop=0 -> frame_err=1.
5. Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> FSM in IDLE, frame_err=1. A following good 0x2A frame is received correctly.
6. Assert clrn mid-frame after 5 bits, then send 0x33 -> only 0x33 is in the FIFO, count=1. With PS2_RX_GLITCH_FILTER_EN, 2-cycle low pulses on ps2_clk cause no bit shifts.
